// File: rtl/step0_out_sequencer.sv
// Transmit-side sequencer for step0: captures NUM-sample butterfly blocks into
// ping-pong banks and streams them downstream over valid/ready with idx/last.
module step0_out_sequencer #(
    parameter int NUM     = 16,
    parameter int WIDTH   = 9,
    parameter int BIT_REV = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bfly_mul_en,
    input  logic signed [WIDTH-1:0] din_re,
    input  logic signed [WIDTH-1:0] din_im,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic signed [WIDTH-1:0] dout_re,
    output logic signed [WIDTH-1:0] dout_im,
    output logic [$clog2(NUM)-1:0]  dout_idx,
    output logic                    dout_last,
    output logic                    overflow
);
    localparam int AW = $clog2(NUM);
    localparam logic [AW-1:0] CNT_LAST = AW'(NUM - 1);

    logic [2*WIDTH-1:0] mem [2][NUM];
    logic [AW-1:0]      wr_cnt;
    logic [AW-1:0]      rd_cnt;
    logic [AW-1:0]      rd_addr;
    logic               wr_bank;
    logic               rd_bank;
    logic [1:0]         bank_full;
    logic [1:0]         bank_full_nxt;
    logic               wr_en;
    logic               wr_done;
    logic               rd_xfer;
    logic               rd_done;
    logic [2*WIDTH-1:0] rd_word;

    function automatic logic [AW-1:0] bit_reverse(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < AW; i++) begin
            r[i] = v[AW-1-i];
        end
        return r;
    endfunction

    always_comb begin
        wr_en      = bfly_mul_en && !bank_full[wr_bank];
        wr_done    = wr_en && (wr_cnt == CNT_LAST);
        dout_valid = bank_full[rd_bank];
        rd_xfer    = dout_valid && dout_ready;
        rd_done    = rd_xfer && (rd_cnt == CNT_LAST);

        // Write completion and drain completion always target different banks.
        bank_full_nxt = bank_full;
        if (wr_done) bank_full_nxt[wr_bank] = 1'b1;
        if (rd_done) bank_full_nxt[rd_bank] = 1'b0;

        rd_addr = (BIT_REV != 0) ? bit_reverse(rd_cnt) : rd_cnt;
        rd_word = mem[rd_bank][rd_addr];

        // Data is masked while idle so reset state reads as zero.
        dout_re   = dout_valid ? rd_word[2*WIDTH-1:WIDTH] : '0;
        dout_im   = dout_valid ? rd_word[WIDTH-1:0]       : '0;
        dout_idx  = rd_cnt;
        dout_last = dout_valid && (rd_cnt == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_bank][wr_cnt] <= {din_re, din_im};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            bank_full <= '0;
            overflow  <= 1'b0;
        end else begin
            bank_full <= bank_full_nxt;

            if (bfly_mul_en) begin
                if (bank_full[wr_bank]) begin
                    overflow <= 1'b1;
                end else if (wr_done) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end

            if (rd_xfer) begin
                if (rd_done) begin
                    rd_cnt  <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_step0_out_sequencer.sv
// Bench for step0_out_sequencer: natural and bit-reversed instances share stimulus
// and are compared each cycle against a queue-based block model.
module tb_step0_out_sequencer;
    localparam int NUM = 16;
    localparam int W   = 9;
    localparam int AW  = $clog2(NUM);
    localparam int PW  = 3 + AW + 2*W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic rdy = 1'b0;
    logic signed [W-1:0] din_re = '0;
    logic signed [W-1:0] din_im = '0;

    logic n_valid, n_last, n_ovf, r_valid, r_last, r_ovf;
    logic signed [W-1:0] n_re, n_im, r_re, r_im;
    logic [AW-1:0] n_idx, r_idx;

    always #5 clk = ~clk;

    step0_out_sequencer #(.NUM(NUM), .WIDTH(W), .BIT_REV(0)) u_nat (
        .clk(clk), .rst(rst), .bfly_mul_en(en), .din_re(din_re), .din_im(din_im),
        .dout_valid(n_valid), .dout_ready(rdy), .dout_re(n_re), .dout_im(n_im),
        .dout_idx(n_idx), .dout_last(n_last), .overflow(n_ovf)
    );

    step0_out_sequencer #(.NUM(NUM), .WIDTH(W), .BIT_REV(1)) u_rev (
        .clk(clk), .rst(rst), .bfly_mul_en(en), .din_re(din_re), .din_im(din_im),
        .dout_valid(r_valid), .dout_ready(rdy), .dout_re(r_re), .dout_im(r_im),
        .dout_idx(r_idx), .dout_last(r_last), .overflow(r_ovf)
    );

    int checks = 0;
    int errors = 0;

    // Model: completed blocks awaiting delivery (oldest first), the block being
    // captured, position within the head block, and the sticky drop flag.
    logic [2*W-1:0] full_q[$];
    logic [2*W-1:0] part_q[$];
    int rd_pos = 0;
    bit ovf_m  = 1'b0;

    function automatic int brev(input int x);
        int r = 0;
        for (int b = 0; b < AW; b++) r = r * 2 + ((x >> b) & 1);
        return r;
    endfunction

    function automatic logic [PW-1:0] exp_out(input bit rev);
        int a;
        if (full_q.size() >= NUM) begin
            a = rev ? brev(rd_pos) : rd_pos;
            return {1'b1, rd_pos == NUM-1, AW'(rd_pos), full_q[a], ovf_m};
        end
        return {2'b00, AW'(rd_pos), {2*W{1'b0}}, ovf_m};
    endfunction

    function automatic logic [PW-1:0] obs(input bit rev);
        if (rev) return {r_valid, r_last, r_idx, r_re, r_im, r_ovf};
        return {n_valid, n_last, n_idx, n_re, n_im, n_ovf};
    endfunction

    // Drives one cycle of stimulus (called at negedge) and advances the model.
    task automatic tick(input bit r, input bit e, input logic [W-1:0] re,
                        input logic [W-1:0] im, input bit rd);
        bit acc, xfer;
        rst = r; en = e; din_re = re; din_im = im; rdy = rd;
        xfer = (full_q.size() >= NUM) && rd;
        acc  = e && (full_q.size() < 2*NUM);
        @(posedge clk);
        if (r) begin
            full_q.delete(); part_q.delete(); rd_pos = 0; ovf_m = 1'b0;
        end else begin
            if (e && !acc) ovf_m = 1'b1;
            if (xfer) begin
                if (rd_pos == NUM-1) begin
                    rd_pos = 0;
                    repeat (NUM) void'(full_q.pop_front());
                end else begin
                    rd_pos++;
                end
            end
            if (acc) begin
                part_q.push_back({re, im});
                if (part_q.size() == NUM) begin
                    foreach (part_q[i]) full_q.push_back(part_q[i]);
                    part_q.delete();
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(1, 0, '0, '0, 0);
        tick(1, 1, 9'd5, 9'd7, 1);
        rst = 1'b0; en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k[0]) !== exp_out(k[0]))
                $display("FAIL reset inst%0d: got %h expected %h", k, obs(k[0]), exp_out(k[0]));
            if (obs(k[0]) !== exp_out(k[0])) errors++;
        end
    endtask

    task automatic test_single_block(input string name);
        for (int c = 0; c < NUM + 20; c++) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k[0]) !== exp_out(k[0])) begin
                    errors++;
                    $display("FAIL %s cyc%0d inst%0d: got %h expected %h", name, c, k, obs(k[0]), exp_out(k[0]));
                end
            end
            if (c < NUM) tick(0, 1, W'(c), W'(-c), 1);
            else         tick(0, 0, '0, '0, 1);
        end
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] prev [2];
        bit stalled;
        tick(1, 0, '0, '0, 0);
        for (int c = 0; c < NUM; c++) tick(0, 1, W'($urandom), W'($urandom), 0);
        stalled = 1'b0;
        for (int c = 0; c < 3*NUM; c++) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k[0]) !== exp_out(k[0])) begin
                    errors++;
                    $display("FAIL backpressure cyc%0d inst%0d: got %h expected %h", c, k, obs(k[0]), exp_out(k[0]));
                end
                if (stalled) begin
                    checks++;
                    if (obs(k[0]) !== prev[k]) begin
                        errors++;
                        $display("FAIL stall_hold cyc%0d inst%0d: got %h expected %h", c, k, obs(k[0]), prev[k]);
                    end
                end
                prev[k] = obs(k[0]);
            end
            stalled = n_valid && !((c % 4 == 0) || (c % 4 == 3));
            tick(0, 0, '0, '0, (c % 4 == 0) || (c % 4 == 3));
        end
    endtask

    task automatic test_pingpong();
        int v;
        tick(1, 0, '0, '0, 0);
        for (int c = 0; c < 2*NUM + 20; c++) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k[0]) !== exp_out(k[0])) begin
                    errors++;
                    $display("FAIL pingpong cyc%0d inst%0d: got %h expected %h", c, k, obs(k[0]), exp_out(k[0]));
                end
            end
            v = (c < NUM) ? c : 100 + c - NUM;
            if (c < 2*NUM) tick(0, 1, W'(v), W'($urandom), 1);
            else           tick(0, 0, '0, '0, 1);
        end
    endtask

    task automatic test_overflow();
        tick(1, 0, '0, '0, 0);
        for (int c = 0; c < 2*NUM + 1; c++) tick(0, 1, W'(c), W'($urandom), 0);
        for (int c = 0; c < 2*NUM + 8; c++) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k[0]) !== exp_out(k[0])) begin
                    errors++;
                    $display("FAIL overflow cyc%0d inst%0d: got %h expected %h", c, k, obs(k[0]), exp_out(k[0]));
                end
            end
            tick(0, 0, '0, '0, 1);
        end
    endtask

    task automatic test_mid_reset();
        tick(1, 0, '0, '0, 0);
        for (int c = 0; c < 2*NUM; c++) tick(0, 1, W'($urandom), W'($urandom), 0);
        for (int c = 0; c < 7; c++) tick(0, 0, '0, '0, 1);
        tick(1, 0, '0, '0, 1);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k[0]) !== exp_out(k[0])) begin
                errors++;
                $display("FAIL mid_reset inst%0d: got %h expected %h", k, obs(k[0]), exp_out(k[0]));
            end
        end
        test_single_block("after_reset");
    endtask

    task automatic test_random();
        tick(1, 0, '0, '0, 0);
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k[0]) !== exp_out(k[0])) begin
                    errors++;
                    $display("FAIL random cyc%0d inst%0d: got %h expected %h", c, k, obs(k[0]), exp_out(k[0]));
                end
            end
            tick(0, $urandom_range(9, 0) < 7, W'($urandom), W'($urandom), $urandom_range(9, 0) < 6);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_block("single_block");
        test_backpressure();
        test_pingpong();
        test_overflow();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
